gpio_reg_arbiter: RTL
=====================

// Module: gpio_reg_arbiter
// PURPOSE
//  Shares the single gpio register port (reg_access/reg_packet/reg_rdata) among NR requesters.
//  Round-robin grant; builds the emesh packet; waits for registered read data; returns it to the owner.
//  Sits between on-chip masters (CPU bridge, DMA, test sequencer) and one gpio instance.
// PARAMETERS
//  NR      4    number of requesters (2..8)
//  AW      32   emesh address width
//  PW      104  packet width, 2*AW+40
//  ID      0    gpio block id, driven on dstaddr[10:8]
//  RD_LAT  1    cycles from read issue to valid reg_rdata (1..3)
// PORTS
//  clk         in   1      clock
//  nreset      in   1      async active-low reset
//  req_valid   in   NR     request pending, per requester
//  req_ready   out  NR     one-hot accept pulse, combinational from req_valid in IDLE
//  req_write   in   NR     1=write, 0=read, per requester
//  req_reg     in   4*NR   gpio register select (GPIO_* regmap codes), slice i = requester i
//  req_wdata   in   32*NR  write data, slice i = requester i
//  rsp_valid   out  NR     one-cycle read-response pulse to owner
//  rsp_rdata   out  32     read data, valid while any rsp_valid bit is high
//  busy        out  1      arbiter not in IDLE
//  reg_access  out  1      packet strobe to gpio
//  reg_packet  out  PW     emesh packet to gpio
//  reg_rdata   in   32     gpio read data
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, rsp_rdata=0, reg_access=0, reg_packet=0, busy=0, last_grant=NR-1.
//  Packet fields: [0] write; [2:1] datamode=2'b10 (32b); [7:3] ctrlmode=0; [39:8] dstaddr;
//   [71:40] data (wdata for writes, 0 for reads); [103:72] srcaddr = requester index.
//  dstaddr = {21'b0, ID[2:0], 1'b0, req_reg[3:0], 3'b0}.
//  FSM, all transitions on clk rising edge:
//  - IDLE: pick the first req_valid bit searching last_grant+1 .. last_grant+NR mod NR.
//    Grant: req_ready[g]=1 for that cycle; latch write/reg/wdata/g; last_grant<=g; ->ISSUE.
//    No req_valid: stay IDLE, req_ready=0.
//  - ISSUE: reg_access=1 for exactly one cycle with the latched packet (registered outputs).
//    Write ->IDLE. Read ->WAIT with cnt=RD_LAT-1.
//  - WAIT: reg_access=0, reg_packet held. cnt==0: rsp_rdata<=reg_rdata, rsp_valid[owner]<=1, ->RESP.
//    Otherwise cnt decrements.
//  - RESP: rsp_valid high this cycle only; ->IDLE.
//  Latency: write grant->reg_access 1 cycle. Read grant->rsp_valid RD_LAT+2 cycles.
//  Throughput: one write per 2 cycles; one read per RD_LAT+3 cycles.
//  Requesters hold valid/write/reg/wdata stable until req_ready; fields change only after acceptance.
//  A requester deasserting valid before grant is legal; it is simply not selected.
//  Simultaneous requests: strict rotation, no requester granted twice while another waits.
//  Holding req_valid after its own grant is legal: that requester is eligible again only after
//   the others have been visited.
//  rsp_rdata holds its last value after the response. No responses for writes.
//  nreset asserted mid-operation: in-flight transaction dropped, no rsp_valid, outputs return
//   to reset values immediately (async).
//  busy = (state != IDLE); req_ready is always 0 while busy.
// STRUCTURE
//  Shared package/include (gpio_regmap.v): GPIO_* register codes, FSM state encodings,
//   emesh field offsets, datamode constant.
//  Sub-module: gpio_rr_arbiter (NR-wide round-robin one-hot pick given req and last_grant,
//   combinational). FSM, packet build and response capture stay in the top.
// TESTING (bench drives gpio instance with RD_LAT=1)
//  1 Single write: req0 write reg=GPIO_ODATA wdata=0x00A5A5A5 -> req_ready[0] in cycle 0,
//    reg_access 1 cycle later with packet[0]=1, data=0x00A5A5A5; gpio_out=0xA5A5A5.
//  2 Readback: req1 read GPIO_ODATA after 1 -> rsp_valid[1] exactly 3 cycles after grant,
//    rsp_rdata=0x00A5A5A5, srcaddr=1.
//  3 Contention: all 4 requesters held valid from reset -> grant order 0,1,2,3,0; no double
//    grant; exactly one req_ready per accepted transaction.
//  4 Input read: gpio_in=0x000081, req2 read GPIO_IDATA -> rsp_rdata=0x00000081 after
//    synchronizer settles; rsp_valid only on bit 2.
//  5 Reset mid-read: assert nreset during WAIT -> reg_access=0, rsp_valid never pulses,
//    busy=0; next grant after release goes to requester 0.
//  6 Late withdraw: req3 drops valid before grant while req1 is busy -> req3 not granted,
//    no reg_access.

Source files
------------

// File: rtl/gpio_reg_arbiter_pkg.sv
//==============================================================================
// gpio_reg_arbiter_pkg : gpio register codes, arbiter FSM states, emesh fields
// Revision: 1.0
//==============================================================================
`default_nettype none

package gpio_reg_arbiter_pkg;

  localparam logic [3:0] GPIO_DIR     = 4'd0;
  localparam logic [3:0] GPIO_IDATA   = 4'd1;
  localparam logic [3:0] GPIO_ODATA   = 4'd2;
  localparam logic [3:0] GPIO_OCLR    = 4'd3;
  localparam logic [3:0] GPIO_OSET    = 4'd4;
  localparam logic [3:0] GPIO_OXOR    = 4'd5;
  localparam logic [3:0] GPIO_IMASK   = 4'd6;
  localparam logic [3:0] GPIO_ITYPE   = 4'd7;
  localparam logic [3:0] GPIO_IPOL    = 4'd8;
  localparam logic [3:0] GPIO_ILAT    = 4'd9;
  localparam logic [3:0] GPIO_ILATCLR = 4'd10;

  localparam logic [1:0] DATAMODE_32 = 2'b10;

  localparam int PKT_WRITE     = 0;
  localparam int PKT_DMODE_LSB = 1;
  localparam int PKT_DST_LSB   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Registers sit on 8-byte strides; block id lives in bits [10:8].
  function automatic logic [31:0] gpio_dstaddr(input logic [2:0] id, input logic [3:0] reg_sel);
    return {21'b0, id, 1'b0, reg_sel, 3'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_rr_arbiter.sv
//==============================================================================
// gpio_rr_arbiter : combinational round-robin one-hot pick after last_grant
// Revision: 1.0
//==============================================================================
`default_nettype none

module gpio_rr_arbiter #(
  parameter int NR = 4,
  parameter int IW = $clog2(NR)
) (
  input  logic [NR-1:0] req,
  input  logic [IW-1:0] last_grant,
  output logic [NR-1:0] grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Search starts one past the previous winner so nobody is served twice in a row while others wait.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NR; k++) begin
      cand     = (int'(last_grant) + k) % NR;
      cand_idx = IW'(cand);
      if (!grant_any && req[cand_idx]) begin
        grant_any       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gpio_reg_arbiter.sv
//==============================================================================
// gpio_reg_arbiter : shares one gpio register port among NR requesters
// Revision: 1.0
//==============================================================================
`default_nettype none

module gpio_reg_arbiter
  import gpio_reg_arbiter_pkg::*;
#(
  parameter int NR     = 4,
  parameter int AW     = 32,
  parameter int PW     = 104,
  parameter int ID     = 0,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [NR-1:0]   req_valid,
  output logic [NR-1:0]   req_ready,
  input  logic [NR-1:0]   req_write,
  input  logic [4*NR-1:0] req_reg,
  input  logic [32*NR-1:0] req_wdata,
  output logic [NR-1:0]   rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            busy,
  output logic            reg_access,
  output logic [PW-1:0]   reg_packet,
  input  logic [31:0]     reg_rdata
);

  localparam int IW       = $clog2(NR);
  localparam int DATA_LSB = PKT_DST_LSB + AW;
  localparam int SRC_LSB  = DATA_LSB + AW;

  arb_state_t    state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] owner;
  logic [IW-1:0] grant_idx;
  logic [NR-1:0] grant;
  logic          grant_any;
  logic          is_write;
  logic [1:0]    cnt;
  logic [PW-1:0] next_packet;
  logic          sel_write;
  logic [3:0]    sel_reg;
  logic [31:0]   sel_wdata;

  gpio_rr_arbiter #(.NR(NR)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  assign busy      = (state != ST_IDLE);
  assign req_ready = (nreset && !busy) ? grant : '0;

  always_comb begin
    sel_write = 1'b0;
    sel_reg   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NR; i++) begin
      if (grant[i]) begin
        sel_write = req_write[i];
        sel_reg   = req_reg[4*i +: 4];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
    next_packet                        = '0;
    next_packet[PKT_WRITE]             = sel_write;
    next_packet[PKT_DMODE_LSB +: 2]    = DATAMODE_32;
    next_packet[PKT_DST_LSB +: AW]     = AW'(gpio_dstaddr(3'(ID), sel_reg));
    next_packet[DATA_LSB +: AW]        = sel_write ? AW'(sel_wdata) : '0;
    next_packet[SRC_LSB +: AW]         = AW'(grant_idx);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      last_grant <= IW'(NR - 1);
      owner      <= '0;
      is_write   <= 1'b0;
      cnt        <= '0;
      reg_access <= 1'b0;
      reg_packet <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            last_grant <= grant_idx;
            owner      <= grant_idx;
            is_write   <= sel_write;
            reg_packet <= next_packet;
            reg_access <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          reg_access <= 1'b0;
          if (is_write) begin
            state <= ST_IDLE;
          end else begin
            cnt   <= 2'(RD_LAT - 1);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 2'd0) begin
            rsp_rdata        <= reg_rdata;
            rsp_valid[owner] <= 1'b1;
            state            <= ST_RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ST_RESP: begin
          rsp_valid <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
